nor3_truth_table_checker: RTL and testbench

- Sequential exerciser for a 3-input NOR gate under test: it sits on the driving end of the gate and is the counterpart of the gate itself.
- On a start pulse it:
  - drives all eight input combinations onto the gate's `a,b,c` inputs in order;
  - waits a programmable settle time for each one;
  - samples the gate output `d` and records it;
  - compares the captured truth table against the expected NOR response.
- It targets the lab board, with `start` on a debounced button and the results on LEDs.

---
 rtl/nor3_truth_table_checker.sv | 147 ++++++++++++++
 tb/tb_nor3_truth_table_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nor3_truth_table_checker.sv
// nor3_truth_table_checker
// Sequential exerciser for a 3-input NOR gate under test. On a start request
// it walks the eight {a,b,c} combinations in order, holds each one for
// SETTLE_CYCLES clocks, samples the gate output and builds the captured truth
// table, then compares it against EXPECT_TT.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               run request, ignored while a run is in progress
//   dut_d               output of the gate under test
//   dut_a/dut_b/dut_c   gate inputs, {a,b,c} = current vector index
//   busy, done          run in progress / run complete (held until next start)
//   pass                captured table equals EXPECT_TT (only while done)
//   result              captured table, bit i = dut_d sampled for vector i
//   err_count           number of mismatching vectors (0..8)
//   fail_index          first mismatching vector, 0 if none
//
// SETTLE_CYCLES must lie in 1..15 so that the settle counter fits in 4 bits.
module nor3_truth_table_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECT_TT     = 8'b0000_0001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_d,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] result,
   output logic [3:0] err_count,
   output logic [2:0] fail_index
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter value at which the current vector is sampled.
   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_e     state_q,  state_d;
   logic [2:0] vec_q,    vec_d;
   logic [3:0] cnt_q,    cnt_d;
   logic [7:0] result_q, result_d;
   logic [3:0] err_q,    err_d;
   logic [2:0] fail_q,   fail_d;
   logic       pass_q,   pass_d;
   logic       busy_q,   busy_d;
   logic       done_q,   done_d;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               vec_d    = 3'd0;
               cnt_d    = 4'd0;
               result_d = 8'h00;
               err_d    = 4'd0;
               fail_d   = 3'd0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
            end
         end
         RUN: begin
            if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               result_d[vec_q] = dut_d;
               if (dut_d != EXPECT_TT[vec_q]) begin
                  err_d = err_q + 4'd1;
                  // Only the first mismatch is remembered.
                  if (err_q == 4'd0) fail_d = vec_q;
               end
               if (vec_q == 3'd7) begin
                  // vec stays at 7 so the drive outputs hold 111 in DONE.
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 4'd0);
               end else begin
                  vec_d = vec_q + 3'd1;
                  cnt_d = 4'd0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vec_q    <= 3'd0;
         cnt_q    <= 4'd0;
         result_q <= 8'h00;
         err_q    <= 4'd0;
         fail_q   <= 3'd0;
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         pass_q   <= pass_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Every output comes straight from a flop, so the gate sees no glitches.
   assign dut_a      = vec_q[2];
   assign dut_b      = vec_q[1];
   assign dut_c      = vec_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign result     = result_q;
   assign err_count  = err_q;
   assign fail_index = fail_q;

endmodule

// File: tb/tb_nor3_truth_table_checker.sv
// Bench for nor3_truth_table_checker: two instances (settle 2 and settle 3),
// each driving a modelled gate selected by gate_mode. A cycle-level model
// derived from the timing rules is compared against both instances after
// every rising edge; directed scenarios add literal end-of-run checks.
module tb_nor3_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start = 2'b00;
   logic [1:0] dut_d;
   logic [1:0] dut_a, dut_b, dut_c, busy, done, pass;
   logic [7:0] result [2];
   logic [3:0] err_count [2];
   logic [2:0] fail_index [2];

   int gate_mode [2] = '{0, 0};   // 0 NOR, 1 stuck-0, 2 OR, 3 NOR broken at 5
   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nor3_truth_table_checker u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_d(dut_d[0]),
      .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_c(dut_c[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .result(result[0]), .err_count(err_count[0]), .fail_index(fail_index[0])
   );

   nor3_truth_table_checker #(.SETTLE_CYCLES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_d(dut_d[1]),
      .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_c(dut_c[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .result(result[1]), .err_count(err_count[1]), .fail_index(fail_index[1])
   );

   function automatic logic gate(input int mode, input logic [2:0] v);
      case (mode)
         0:       return (v == 3'd0);
         1:       return 1'b0;
         2:       return (v != 3'd0);
         default: return (v == 3'd0) || (v == 3'd5);
      endcase
   endfunction

   function automatic logic [7:0] table_of(input int mode);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = gate(mode, 3'(i));
      return t;
   endfunction

   function automatic int settle_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   always_comb begin
      dut_d = 2'b00;
      for (int k = 0; k < 2; k++)
         dut_d[k] = gate(gate_mode[k], {dut_a[k], dut_b[k], dut_c[k]});
   end

   // Model: m_j counts edges since the accepting edge E0.
   bit m_act [2];
   int m_j [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
            m_j[k]   = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (start[k] && !(m_act[k] && m_j[k] < 8 * settle_of(k))) begin
               m_act[k] = 1'b1;
               m_j[k]   = 0;
            end else if (m_act[k] && m_j[k] < 8 * settle_of(k)) begin
               m_j[k] = m_j[k] + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: all outputs of both instances after every edge.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         int s, nsamp, v, first;
         logic [7:0] tbl, mask, mism;
         logic       e_busy, e_done, e_pass;
         logic [20:0] exp_v, act_v;
         s     = settle_of(k);
         nsamp = m_act[k] ? ((m_j[k] / s > 8) ? 8 : m_j[k] / s) : 0;
         v     = m_act[k] ? ((m_j[k] / s > 7) ? 7 : m_j[k] / s) : 0;
         tbl   = table_of(gate_mode[k]);
         mask  = 8'((9'd1 << nsamp) - 9'd1);
         mism  = (tbl ^ 8'h01) & mask;
         first = 0;
         for (int i = 7; i >= 0; i--) if (mism[i]) first = i;
         e_busy = m_act[k] && (m_j[k] < 8 * s);
         e_done = m_act[k] && (m_j[k] == 8 * s);
         e_pass = e_done && (mism == 8'h00);
         exp_v = {e_busy, e_done, e_pass, tbl & mask, 4'($countones(mism)),
                  3'(first), 3'(v)};
         act_v = {busy[k], done[k], pass[k], result[k], err_count[k],
                  fail_index[k], dut_a[k], dut_b[k], dut_c[k]};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_dut%0d: got busy/done/pass/res/err/fi/abc=%h expected %h at %0t",
                     k, act_v, exp_v, $time);
         end
      end
   end

   // Runs one test on instance k; returns after done or a cycle bound.
   task automatic run_case(input int k, input int mode, input int exp_n,
                           input logic [7:0] e_res, input int e_err,
                           input int e_fi, input int e_pass, input bit mid_pulse);
      int n;
      @(negedge clk);
      gate_mode[k] = mode;
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!done[k] && n < 100) begin
         @(negedge clk);
         start[k] = (mid_pulse && n == 5);
         @(posedge clk);
         #1;
         n++;
      end
      start[k] = 1'b0;
      chk($sformatf("latency_dut%0d_m%0d", k, mode), n, exp_n);
      chk($sformatf("result_dut%0d_m%0d", k, mode), int'(result[k]), int'(e_res));
      chk($sformatf("err_dut%0d_m%0d", k, mode), int'(err_count[k]), e_err);
      chk($sformatf("fail_idx_dut%0d_m%0d", k, mode), int'(fail_index[k]), e_fi);
      chk($sformatf("pass_dut%0d_m%0d", k, mode), int'(pass[k]), e_pass);
      chk($sformatf("abc_done_dut%0d", k), int'({dut_a[k], dut_b[k], dut_c[k]}), 7);
   endtask

   initial begin
      int done_cyc [$];
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({busy, done, pass, result[0], err_count[0], fail_index[0]}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_case(0, 0, 16, 8'h01, 0, 0, 1, 1'b0);
      run_case(0, 1, 16, 8'h00, 1, 0, 0, 1'b0);
      run_case(0, 2, 16, 8'hFE, 8, 0, 0, 1'b0);
      run_case(1, 3, 24, 8'h21, 1, 5, 0, 1'b0);
      run_case(0, 0, 16, 8'h01, 0, 0, 1, 1'b1);   // start pulsed mid-run

      // Reset at cycle 7 of a run.
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_before_reset", int'(busy[0]), 1);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_status", int'({busy[0], done[0], pass[0]}), 0);
      chk("midrun_reset_table", int'({result[0], err_count[0], fail_index[0]}), 0);
      chk("midrun_reset_abc", int'({dut_a[0], dut_b[0], dut_c[0]}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_case(0, 0, 16, 8'h01, 0, 0, 1, 1'b0);   // repeat gives same table

      // start tied high: done once every 17 cycles.
      @(negedge clk);
      gate_mode[0] = 0;
      start[0] = 1'b1;
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk);
         #1;
         if (done[0]) begin
            done_cyc.push_back(i);
            chk("tied_result", int'(result[0]), 8'h01);
         end
      end
      @(negedge clk);
      start[0] = 1'b0;
      chk("tied_done_count", done_cyc.size(), 4);
      if (done_cyc.size() > 0) chk("tied_first_done", done_cyc[0], 17);
      for (int i = 1; i < done_cyc.size(); i++)
         chk("tied_period", done_cyc[i] - done_cyc[i-1], 17);

      repeat (20) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
